// File: rtl/lpc_mem_pkg.sv
// Shared types and defaults for the LPC speech-buffer read path.
// Holds window geometry defaults and the sequencer state encoding.
package lpc_mem_pkg;

  localparam int WIN_LEN_DEF = 240;
  localparam int ADDR_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/lpc_window_sequencer_skid.sv
// lpc_seq_skid: 2-entry fall-through register buffer for RAM read data.
// Ports: clock, reset, in_valid/in_data (RAM side), out_valid/out_ready/
// out_data (consumer side), free (empty slots, 0..2).
module lpc_seq_skid #(
  parameter int W = 41
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   free
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   count;
  logic         pop;

  // Empty buffer passes RAM data straight through so the
  // RAM latency is the only latency on the stream.
  assign out_valid = (count != 2'd0) || in_valid;
  assign pop       = out_valid && out_ready;
  assign free      = 2'd2 - count;

  always_comb begin
    out_data = '0;
    if (count != 2'd0)
      out_data = head;
    else if (in_valid)
      out_data = in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case (count)
        2'd0: begin
          if (in_valid && !out_ready) begin
            head  <= in_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (pop) begin
            if (in_valid)
              head <= in_data;
            else
              count <= 2'd0;
          end else if (in_valid) begin
            tail  <= in_data;
            count <= 2'd2;
          end
        end
        default: begin
          // The issuer never lets a third word arrive while full.
          if (pop) begin
            head <= tail;
            if (in_valid)
              tail <= in_data;
            else
              count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/lpc_window_sequencer.sv
// Reads one WIN_LEN-word window from the circular speech buffer, oldest
// word first, and streams it to the autocorrelator over valid/ready.
// Ports: clock, reset (sync, active-high), frame_start, wr_ptr,
// mem_rd_addr/mem_rd_data (1-cycle sync RAM), smp_valid/smp_ready/
// smp_data/smp_index/smp_last, busy, win_done.
// Option LPC_SEQ_OVERRUN_EN adds overrun: frame_start seen while busy.
module lpc_window_sequencer
  import lpc_mem_pkg::*;
#(
  parameter int WIN_LEN  = WIN_LEN_DEF,
  parameter int BUF_BASE = 0,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [31:0]       smp_data,
  output logic [ADDR_W-1:0] smp_index,
  output logic              smp_last,
  output logic              busy,
  output logic              win_done
`ifdef LPC_SEQ_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  localparam int SW = 32 + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(WIN_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BUF_BASE);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  seq_state_t state, state_nx;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] start;
  logic [ADDR_W-1:0] tag_idx;
  logic              tag_last;
  logic              inflight;
  logic              issue;
  logic              load;
  logic              accept;
  logic              room;
  logic [1:0]        free;
  logic [SW-1:0]     out_word;

  assign start  = (32'(wr_ptr) >= WIN_LEN) ? '0 : wr_ptr;
  assign accept = smp_valid && smp_ready;

  // Words held + word in flight - word leaving now must stay
  // below 2, so the next read always has a slot to land in.
  assign room = ({1'b0, free} + {2'b00, accept}) > {2'b00, inflight};

  assign busy        = (state != IDLE);
  assign mem_rd_addr = issue ? BASE + ptr : addr_q;

`ifdef LPC_SEQ_OVERRUN_EN
  assign overrun = frame_start && ((state == READ) || (state == DRAIN));
`endif

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    load     = 1'b0;
    win_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          load     = 1'b1;
          state_nx = READ;
        end
      end
      READ: begin
        if (room) begin
          issue = 1'b1;
          if (cnt == TOP)
            state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && smp_last)
          state_nx = DONE;
      end
      DONE: begin
        win_done = 1'b1;
        if (frame_start) begin
          load     = 1'b1;
          state_nx = READ;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr      <= '0;
      cnt      <= '0;
      addr_q   <= BASE;
      inflight <= 1'b0;
      tag_idx  <= '0;
      tag_last <= 1'b0;
    end else begin
      addr_q   <= mem_rd_addr;
      inflight <= issue;
      if (load) begin
        ptr <= start;
        cnt <= '0;
      end else if (issue) begin
        // Wrap by compare, not by modulo.
        ptr      <= (ptr == TOP) ? '0 : ptr + ONE;
        cnt      <= cnt + ONE;
        tag_idx  <= cnt;
        tag_last <= (cnt == TOP);
      end
    end
  end

  lpc_seq_skid #(
    .W(SW)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inflight),
    .in_data   ({mem_rd_data, tag_idx, tag_last}),
    .out_valid (smp_valid),
    .out_ready (smp_ready),
    .out_data  (out_word),
    .free      (free)
  );

  assign smp_data  = out_word[SW-1 -: 32];
  assign smp_index = out_word[ADDR_W:1];
  assign smp_last  = out_word[0];

endmodule

// File: tb/tb_lpc_window_sequencer.sv
// Self-checking bench for lpc_window_sequencer with a behavioural RAM
// and a window model computed as mem[(start + k) % WIN_LEN].
module tb_lpc_window_sequencer;

  localparam int WL = 240;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        smp_ready = 1'b0;
  logic [7:0]  wr_ptr = '0;
  logic [7:0]  mem_rd_addr;
  logic [7:0]  smp_index;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] smp_data;
  logic        smp_valid;
  logic        smp_last;
  logic        busy;
  logic        win_done;
`ifdef LPC_SEQ_OVERRUN_EN
  logic        overrun;
`endif

  logic [31:0] mem [256];
  int cyc = 0;
  int nerr = 0;
  int nchk = 0;
  int fs_cyc, done_cyc, stall_bad, busy_bad, ovr_cnt, ovr_cyc;
  logic [31:0] q_data [$];
  int          q_idx  [$];
  logic        q_last [$];
  int          q_cyc  [$];
  int          q_addr [$];

  lpc_window_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .wr_ptr      (wr_ptr),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .smp_valid   (smp_valid),
    .smp_ready   (smp_ready),
    .smp_data    (smp_data),
    .smp_index   (smp_index),
    .smp_last    (smp_last),
    .busy        (busy),
    .win_done    (win_done)
`ifdef LPC_SEQ_OVERRUN_EN
    ,
    .overrun     (overrun)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic start_frame(input logic [7:0] p);
    @(negedge clock);
    wr_ptr = p;
    frame_start = 1'b1;
    fs_cyc = cyc;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  // Runs the stream until win_done, recording every accepted sample.
  task automatic collect(input int pct, input int fs_rel, input int budget);
    logic        pv, pl;
    logic [31:0] pd;
    logic [7:0]  pi;
    bit          got;
    q_data.delete(); q_idx.delete(); q_last.delete();
    q_cyc.delete(); q_addr.delete();
    stall_bad = 0; busy_bad = 0; ovr_cnt = 0; ovr_cyc = -1;
    done_cyc = -1; pv = 0; pl = 0; pd = '0; pi = '0; got = 0;
    for (int n = 0; n < budget && !got; n++) begin
      smp_ready = ($urandom_range(99) < 32'(pct));
      frame_start = (fs_rel >= 0) && (cyc == fs_cyc + fs_rel);
      if (frame_start) wr_ptr = 8'($urandom);
      #1;
      q_addr.push_back(int'(mem_rd_addr));
      if (pv && (!smp_valid || smp_data !== pd ||
                 smp_index !== pi || smp_last !== pl))
        stall_bad++;
      if (!busy) busy_bad++;
`ifdef LPC_SEQ_OVERRUN_EN
      if (overrun) begin ovr_cnt++; ovr_cyc = cyc; end
`endif
      if (smp_valid && smp_ready) begin
        q_data.push_back(smp_data);
        q_idx.push_back(int'(smp_index));
        q_last.push_back(smp_last);
        q_cyc.push_back(cyc);
      end
      pv = smp_valid && !smp_ready;
      pd = smp_data; pi = smp_index; pl = smp_last;
      if (win_done) begin
        done_cyc = cyc;
        got = 1;
      end else begin
        @(negedge clock);
      end
    end
    frame_start = 1'b0;
    if (!got) begin
      nchk++; nerr++;
      $display("FAIL collect_timeout: no win_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    nchk++;
    if ({smp_valid, smp_last, busy, win_done} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_flags: got %b want 0000",
               {smp_valid, smp_last, busy, win_done});
    end
    nchk++;
    if (smp_data !== 32'd0 || smp_index !== 8'd0) begin
      nerr++;
      $display("FAIL reset_data: got %h/%0d want 0/0", smp_data, smp_index);
    end
    nchk++;
    if (mem_rd_addr !== 8'd0) begin
      nerr++;
      $display("FAIL reset_addr: got %0d want 0", mem_rd_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_linear();
    logic [31:0] e;
    start_frame(8'd0);
    collect(100, -1, 1000);
    nchk++;
    if (q_data.size() != WL) begin
      nerr++;
      $display("FAIL lin_count: got %0d want %0d", q_data.size(), WL);
    end
    for (int k = 0; k < q_data.size() && k < WL; k++) begin
      e = mem[k];
      nchk++;
      if (q_data[k] !== e || q_idx[k] != k || q_last[k] !== (k == WL-1)) begin
        nerr++;
        $display("FAIL lin_smp[%0d]: got %h/%0d/%b want %h/%0d/%b", k,
                 q_data[k], q_idx[k], q_last[k], e, k, k == WL-1);
      end
    end
    for (int k = 0; k < WL && k < q_addr.size(); k++) begin
      nchk++;
      if (q_addr[k] != k) begin
        nerr++;
        $display("FAIL lin_addr[%0d]: got %0d want %0d", k, q_addr[k], k);
      end
    end
    nchk++;
    if (q_cyc.size() == 0 || q_cyc[0] != fs_cyc + 2) begin
      nerr++;
      $display("FAIL lin_first_cyc: got %0d want %0d",
               q_cyc.size() ? q_cyc[0] - fs_cyc : -1, 2);
    end
    nchk++;
    if (q_cyc.size() == 0 || q_cyc[q_cyc.size()-1] != fs_cyc + 241) begin
      nerr++;
      $display("FAIL lin_last_cyc: got %0d want 241",
               q_cyc.size() ? q_cyc[q_cyc.size()-1] - fs_cyc : -1);
    end
    nchk++;
    if (done_cyc != fs_cyc + 242) begin
      nerr++;
      $display("FAIL lin_done_cyc: got %0d want 242", done_cyc - fs_cyc);
    end
    nchk++;
    if (busy_bad != 0) begin
      nerr++;
      $display("FAIL lin_busy: low for %0d cycles want 0", busy_bad);
    end
    @(negedge clock);
    #1;
    nchk++;
    if (busy !== 1'b0 || win_done !== 1'b0) begin
      nerr++;
      $display("FAIL lin_after: busy=%b done=%b want 0/0", busy, win_done);
    end
    nchk++;
    if (mem_rd_addr !== 8'd239) begin
      nerr++;
      $display("FAIL lin_addr_hold: got %0d want 239", mem_rd_addr);
    end
  endtask

  task automatic test_wrap(input logic [7:0] p, input int s, input int pct);
    logic [31:0] e;
    start_frame(p);
    collect(pct, -1, 3000);
    nchk++;
    if (q_data.size() != WL) begin
      nerr++;
      $display("FAIL wrap%0d_count: got %0d want %0d", p, q_data.size(), WL);
    end
    for (int k = 0; k < q_data.size() && k < WL; k++) begin
      e = mem[(s + k) % WL];
      nchk++;
      if (q_data[k] !== e || q_idx[k] != k || q_last[k] !== (k == WL-1)) begin
        nerr++;
        $display("FAIL wrap%0d_smp[%0d]: got %h/%0d/%b want %h/%0d/%b", p, k,
                 q_data[k], q_idx[k], q_last[k], e, k, k == WL-1);
      end
    end
    nchk++;
    if (stall_bad != 0) begin
      nerr++;
      $display("FAIL wrap%0d_stall: %0d unstable cycles want 0", p, stall_bad);
    end
  endtask

  task automatic test_overlap();
    logic [31:0] e;
    start_frame(8'd33);
    collect(100, 100, 1000);
    nchk++;
    if (q_data.size() != WL || done_cyc != fs_cyc + 242) begin
      nerr++;
      $display("FAIL ovl_len: got %0d smp done@%0d want %0d done@242",
               q_data.size(), done_cyc - fs_cyc, WL);
    end
    for (int k = 0; k < q_data.size() && k < WL; k++) begin
      e = mem[(33 + k) % WL];
      nchk++;
      if (q_data[k] !== e || q_idx[k] != k) begin
        nerr++;
        $display("FAIL ovl_smp[%0d]: got %h/%0d want %h/%0d",
                 k, q_data[k], q_idx[k], e, k);
      end
    end
`ifdef LPC_SEQ_OVERRUN_EN
    nchk++;
    if (ovr_cnt != 1 || ovr_cyc != fs_cyc + 100) begin
      nerr++;
      $display("FAIL ovl_overrun: got %0d pulses @%0d want 1 @100",
               ovr_cnt, ovr_cyc - fs_cyc);
    end
`endif
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    start_frame(8'd5);
    collect(100, -1, 1000);
    wr_ptr = 8'd80;
    frame_start = 1'b1;
    fs_cyc = cyc;
    @(negedge clock);
    frame_start = 1'b0;
    collect(100, -1, 1000);
    nchk++;
    if (q_data.size() == 0 || q_data[0] !== mem[80] || q_cyc[0] != fs_cyc + 2) begin
      nerr++;
      $display("FAIL b2b_first: got %h@%0d want %h@2",
               q_data.size() ? q_data[0] : 32'hx,
               q_cyc.size() ? q_cyc[0] - fs_cyc : -1, mem[80]);
    end
    nchk++;
    if (q_data.size() != WL) begin
      nerr++;
      $display("FAIL b2b_count: got %0d want %0d", q_data.size(), WL);
    end
    for (int k = 0; k < q_data.size() && k < WL; k++) begin
      e = mem[(80 + k) % WL];
      nchk++;
      if (q_data[k] !== e || q_idx[k] != k) begin
        nerr++;
        $display("FAIL b2b_smp[%0d]: got %h/%0d want %h/%0d",
                 k, q_data[k], q_idx[k], e, k);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    start_frame(8'd120);
    for (int n = 0; n < 400 && !hit; n++) begin
      smp_ready = 1'b1;
      #1;
      if (smp_valid && smp_index == 8'd57) begin
        smp_ready = 1'b0;
        reset = 1'b1;
        hit = 1;
      end
      @(negedge clock);
    end
    nchk++;
    if (!hit) begin
      nerr++;
      $display("FAIL rst_mid_reach: index 57 not seen want seen");
    end
    #1;
    nchk++;
    if ({smp_valid, smp_last, busy, win_done} !== 4'b0000 ||
        smp_data !== 32'd0 || smp_index !== 8'd0 || mem_rd_addr !== 8'd0) begin
      nerr++;
      $display("FAIL rst_mid_vals: got %b %h %0d %0d want 0000 0 0 0",
               {smp_valid, smp_last, busy, win_done},
               smp_data, smp_index, mem_rd_addr);
    end
    reset = 1'b0;
    start_frame(8'd3);
    collect(100, -1, 1000);
    nchk++;
    if (q_data.size() != WL || q_idx[0] != 0 || q_data[0] !== mem[3]) begin
      nerr++;
      $display("FAIL rst_mid_restart: got n=%0d idx0=%0d d0=%h want %0d 0 %h",
               q_data.size(), q_data.size() ? q_idx[0] : -1,
               q_data.size() ? q_data[0] : 32'hx, WL, mem[3]);
    end
    @(negedge clock);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    test_reset();
    test_linear();
    test_wrap(8'd200, 200, 100);
    test_wrap(8'd17, 17, 50);
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    test_wrap(8'd250, 0, 100);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/lpc_window_sequencer.md
# lpc_window_sequencer

Read-side sequencer for the 240-word circular speech buffer. The buffer is filled by the pre-processing write path; this block reads it out for the autocorrelation block. On each frame-start pulse it latches the buffer's write pointer and issues 240 sequential read addresses, oldest sample first, wrapping modulo the window length. It streams the returned words to the autocorrelation datapath over a valid/ready handshake, with full backpressure support, and flags completion.

## Interface
- WIN_LEN, 240, number of words per analysis window (circular buffer depth)
- BUF_BASE, 0, physical address of buffer word 0
- ADDR_W, 8, address width
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  single-cycle pulse: a new 80-sample frame has been written
- wr_ptr  in  ADDR_W  buffer-relative index of the next word to be written, i.e. the oldest sample
- mem_rd_addr  out  ADDR_W  read address to speech memory read port; synchronous RAM, 1-cycle latency
- mem_rd_data  in  32  read data, valid the cycle after mem_rd_addr
- smp_valid  out  1  smp_data holds a sample
- smp_ready  in  1  consumer accepts the sample this cycle
- smp_data  out  32  sign-extended speech sample
- smp_index  out  ADDR_W  window index 0..WIN_LEN-1 of smp_data
- smp_last  out  1  high together with the index WIN_LEN-1 sample
- busy  out  1  window transfer in progress
- win_done  out  1  one-cycle pulse after the last sample is accepted

## Operation
- States:
  - IDLE: wait for frame_start.
  - READ: issue addresses.
  - DRAIN: all 240 addresses issued; wait for the final accept.
  - DONE: assert win_done for one cycle, then go to IDLE.
- IDLE + frame_start:
  - latch start = (wr_ptr >= WIN_LEN) ? 0 : wr_ptr;
  - clear issue count i and accept count;
  - go to READ.
- READ:
  - mem_rd_addr = BUF_BASE + ((start + i) mod WIN_LEN);
  - i increments only when a read is issued;
  - a read is issued only when the skid buffer has a free slot, counting any in-flight read;
  - after i = WIN_LEN-1 is issued, go to DRAIN.
- Wrap: the mod is a compare-and-subtract. Never use a divider.
- The index stream is always 0..239 in order. Example: with start = 200, physical indices 200..239 are followed by 0..199.
- A sample is accepted when smp_valid && smp_ready. The accept counter drives smp_index.
- The last accept (index WIN_LEN-1) moves DRAIN to DONE.
- frame_start while busy is ignored.
- frame_start during the DONE cycle is accepted: the next state is READ with the new start latched.
- mem_rd_addr holds its last value when no read is issued. No read enable is needed.

## Timing
- Reset values: state IDLE; mem_rd_addr = BUF_BASE; smp_valid, smp_last, busy, win_done = 0; smp_data = 0; smp_index = 0.
- Reset mid-transfer returns to IDLE next cycle. In-flight read data is discarded.
- The first smp_valid rises 2 cycles after the frame_start cycle (issue cycle + RAM latency).
- Throughput is 1 sample per cycle while smp_ready stays high, so a window takes 240 cycles.
  - frame_start at cycle 0 gives the last accept at cycle 241 and win_done at cycle 242.
- Backpressure: while smp_valid && !smp_ready, smp_data, smp_index and smp_last hold stable. No sample is dropped or duplicated.
- busy is high from the cycle after frame_start through the win_done cycle.

## Configuration
- LPC_SEQ_OVERRUN_EN
  - Defined: adds output port overrun (1 bit, reset 0). overrun pulses for one cycle when frame_start arrives in READ or DRAIN. The frame_start is still ignored.
  - Undefined: the port is absent and a frame_start while busy is silently dropped.

## Structure
- Shared package lpc_mem_pkg holds:
  - WIN_LEN_DEF = 240;
  - ADDR_W_DEF = 8;
  - state enum seq_state_t {IDLE, READ, DRAIN, DONE}.
- One sub-module: lpc_seq_skid, a 2-entry, 32+ADDR_W+1 bit register buffer.
  - It provides in_valid / out_ready / free-slot count.
  - It absorbs the 1-cycle RAM latency under backpressure.

## Test plan
- wr_ptr = 0, frame_start, smp_ready held 1 -> addresses 0..239; smp_index 0..239 consecutive; smp_last at index 239; win_done at cycle 242; busy low afterwards.
- wr_ptr = 200, memory preloaded with word = address -> smp_data sequence 200..239 then 0..199; exactly 240 accepts.
- smp_ready toggled randomly (≈50%), wr_ptr = 17 -> sample sequence identical to the ready=1 case; data stable while stalled; no duplicates.
- frame_start again at cycle 100 of a transfer -> ignored; transfer completes normally; with LPC_SEQ_OVERRUN_EN, overrun = 1 for exactly that cycle.
- frame_start in the win_done cycle with wr_ptr = 80 -> new transfer starts immediately; first smp_data = mem[80].
- reset asserted at index 57 with smp_ready = 0 -> next cycle all outputs at reset values; a following frame_start restarts at index 0.
- wr_ptr = 250 (out of range) -> start treated as 0.
